// File: rtl/gt_rx_word_align_if.sv
// gt_rx_word_align_if
//   Bundles the GT-facing RX word and the aligned output stream of the
//   word aligner so that both ends share one set of widths.
//
//   i_rxdata      8*BYTES  raw RX word, byte b = bits [8b+7:8b]
//   i_rxcharisk   BYTES    per-byte K flag
//   i_rx_aligned  1        GT byte-alignment level
//   o_data        8*BYTES  lane-rotated word (comma in byte 0)
//   o_charisk     BYTES    lane-rotated K flags
//   o_valid       1        output word belongs to a locked stream
//   o_locked      1        aligner is locked
//   o_offset      OFFW     locked comma lane
//   o_lock_lost   1        one-cycle pulse when lock is dropped
//   o_err_cnt     16       saturating wrong-lane comma count
//
//   master: the GT / stimulus side. slave: the aligner.
interface gt_rx_word_align_if #(
    parameter int BYTES = 4,
    parameter int OFFW  = $clog2(BYTES)
);
    logic [8*BYTES-1:0] i_rxdata;
    logic [BYTES-1:0]   i_rxcharisk;
    logic               i_rx_aligned;
    logic [8*BYTES-1:0] o_data;
    logic [BYTES-1:0]   o_charisk;
    logic               o_valid;
    logic               o_locked;
    logic [OFFW-1:0]    o_offset;
    logic               o_lock_lost;
    logic [15:0]        o_err_cnt;

    modport master (
        output i_rxdata, i_rxcharisk, i_rx_aligned,
        input  o_data, o_charisk, o_valid, o_locked, o_offset, o_lock_lost, o_err_cnt
    );

    modport slave (
        input  i_rxdata, i_rxcharisk, i_rx_aligned,
        output o_data, o_charisk, o_valid, o_locked, o_offset, o_lock_lost, o_err_cnt
    );
endinterface

// File: rtl/gt_rx_word_align.sv
// gt_rx_word_align
//   Finds the byte lane carrying the comma K-character in each BYTES-wide
//   RX word and rotates data/charisk so the comma always sits in byte 0.
//   A hunt/verify/lock state machine with hysteresis decides which lane to
//   trust; status outputs report lock, lane, lock loss and a saturating
//   count of commas seen on the wrong lane while locked.
//
//   i_rx_clk    RX user clock
//   i_rx_rst_n  asynchronous active-low reset (released synchronously inside)
//   bus         gt_rx_word_align_if.slave, see the interface header
module gt_rx_word_align #(
    parameter int         BYTES      = 4,
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_CNT   = 4,
    parameter int         UNLOCK_CNT = 8,
    parameter int         OFFW       = $clog2(BYTES)
) (
    input  logic              i_rx_clk,
    input  logic              i_rx_rst_n,
    gt_rx_word_align_if.slave bus
);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

    // Reset asserts asynchronously but leaves on a clock edge, so no flop
    // sees a release racing the clock.
    logic [1:0] rst_sync_reg;
    logic       rst_n_int;

    always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
        if (!i_rx_rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync_reg[1];

    state_t             state_reg;
    logic [8*BYTES-1:0] prev_reg;
    logic [BYTES-1:0]   prevk_reg;
    logic [OFFW-1:0]    cand_reg;
    logic [3:0]         vcnt_reg;
    logic [3:0]         mcnt_reg;
    logic [8*BYTES-1:0] data_reg;
    logic [BYTES-1:0]   charisk_reg;
    logic               valid_reg;
    logic               locked_reg;
    logic [OFFW-1:0]    offset_reg;
    logic               lock_lost_reg;
    logic [15:0]        err_cnt_reg;

    // Comma detection on the incoming word.
    logic [BYTES-1:0] hit;
    logic             any_hit;
    logic [OFFW-1:0]  hit_lane;

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_hit
            assign hit[gi] = bus.i_rxcharisk[gi] && (bus.i_rxdata[8*gi +: 8] == COMMA);
        end
    endgenerate

    assign any_hit = |hit;

    // Lowest lane wins when several commas share a word.
    always_comb begin
        hit_lane = '0;
        for (int b = BYTES - 1; b >= 0; b--) begin
            if (hit[b]) hit_lane = OFFW'(b);
        end
    end

    // Rotation window: previous word in the low bytes, current word above.
    // The current word's top byte can never reach the output, so it is
    // left out of the window.
    logic [8*(2*BYTES-1)-1:0] cat;
    logic [2*BYTES-2:0]       kcat;
    logic [8*BYTES-1:0]       rot_data;
    logic [BYTES-1:0]         rot_k;

    assign cat  = {bus.i_rxdata[8*BYTES-9:0], prev_reg};
    assign kcat = {bus.i_rxcharisk[BYTES-2:0], prevk_reg};

    always_comb begin
        rot_data = '0;
        rot_k    = '0;
        for (int o = 0; o < BYTES; o++) begin
            if (offset_reg == OFFW'(o)) begin
                rot_data = cat[8*o +: 8*BYTES];
                rot_k    = kcat[o +: BYTES];
            end
        end
    end

    always_ff @(posedge i_rx_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg     <= ST_HUNT;
            prev_reg      <= '0;
            prevk_reg     <= '0;
            cand_reg      <= '0;
            vcnt_reg      <= '0;
            mcnt_reg      <= '0;
            data_reg      <= '0;
            charisk_reg   <= '0;
            valid_reg     <= 1'b0;
            locked_reg    <= 1'b0;
            offset_reg    <= '0;
            lock_lost_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            prev_reg      <= bus.i_rxdata;
            prevk_reg     <= bus.i_rxcharisk;
            data_reg      <= rot_data;
            charisk_reg   <= rot_k;
            valid_reg     <= locked_reg;
            lock_lost_reg <= 1'b0;

            if (!bus.i_rx_aligned) begin
                // Losing GT byte alignment invalidates every lane decision.
                if (state_reg == ST_LOCKED) lock_lost_reg <= 1'b1;
                state_reg  <= ST_HUNT;
                locked_reg <= 1'b0;
                vcnt_reg   <= '0;
                mcnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_HUNT: begin
                        if (any_hit) begin
                            cand_reg <= hit_lane;
                            vcnt_reg <= 4'd1;
                            if (LOCK_CNT == 1) begin
                                state_reg  <= ST_LOCKED;
                                offset_reg <= hit_lane;
                                locked_reg <= 1'b1;
                                mcnt_reg   <= '0;
                            end else begin
                                state_reg <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (any_hit) begin
                            if (hit_lane == cand_reg) begin
                                vcnt_reg <= vcnt_reg + 4'd1;
                                if (vcnt_reg + 4'd1 == LOCK_N) begin
                                    state_reg  <= ST_LOCKED;
                                    offset_reg <= cand_reg;
                                    locked_reg <= 1'b1;
                                    mcnt_reg   <= '0;
                                end
                            end else begin
                                cand_reg <= hit_lane;
                                vcnt_reg <= 4'd1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (any_hit) begin
                            if (hit_lane == offset_reg) begin
                                mcnt_reg <= '0;
                            end else begin
                                if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
                                if (mcnt_reg + 4'd1 == UNLOCK_N) begin
                                    state_reg     <= ST_HUNT;
                                    locked_reg    <= 1'b0;
                                    lock_lost_reg <= 1'b1;
                                    vcnt_reg      <= '0;
                                    mcnt_reg      <= '0;
                                end else begin
                                    mcnt_reg <= mcnt_reg + 4'd1;
                                end
                            end
                        end
                    end
                    default: state_reg <= ST_HUNT;
                endcase
            end
        end
    end

    assign bus.o_data      = data_reg;
    assign bus.o_charisk   = charisk_reg;
    assign bus.o_valid     = valid_reg;
    assign bus.o_locked    = locked_reg;
    assign bus.o_offset    = offset_reg;
    assign bus.o_lock_lost = lock_lost_reg;
    assign bus.o_err_cnt   = err_cnt_reg;
endmodule

// File: doc/gt_rx_word_align.md
Name: gt_rx_word_align

Overview:
- Parametrised RX word aligner between a GT channel's RX user-clock outputs and the protocol logic.
- Byte alignment from the GT (rx_aligned) only places commas on *some* byte lane. This block finds the comma lane in the BYTES-wide parallel word and rotates data and charisk so the comma always lands in byte 0.
- Hunt/verify/lock state machine with hysteresis, plus lock status and a misalignment error counter.
- Generalises the fixed 32-bit, 4-byte path to any byte count.

Parameters:
- BYTES, 4, bytes per parallel word (2, 4 or 8).
- COMMA, 8'hBC, K-character marking word start (K28.5).
- LOCK_CNT, 4, consecutive same-lane commas required to lock (range 1..15).
- UNLOCK_CNT, 8, consecutive wrong-lane commas that drop lock (range 1..15).
- OFFW, $clog2(BYTES), width of the lane offset.

Ports:
- i_rx_clk  in  1  RX user clock (GT usrclk2 domain).
- i_rx_rst_n  in  1  Asynchronous, active-low reset.
- i_rxdata  in  8*BYTES  RX data from the GT; byte b = bits [8b+7:8b].
- i_rxcharisk  in  BYTES  Per-byte K flag.
- i_rx_aligned  in  1  GT byte-aligned indication, level.
- o_data  out  8*BYTES  Lane-rotated data.
- o_charisk  out  BYTES  Lane-rotated K flags.
- o_valid  out  1  o_data belongs to a locked stream.
- o_locked  out  1  FSM in LOCKED.
- o_offset  out  OFFW  Locked comma lane.
- o_lock_lost  out  1  One-cycle pulse on LOCKED->HUNT.
- o_err_cnt  out  16  Saturating count of wrong-lane commas seen while LOCKED.

Behaviour:
- Reset (async assert, sync deassert inside block): all outputs 0, prev register 0, state HUNT, counters 0.
- Comma detect (combinational on the input word):
  - hit[b] = i_rxcharisk[b] && i_rxdata byte b == COMMA.
  - p = lowest b with hit[b]=1; any_hit = |hit.
  - Multiple commas in one word: lowest index is used.
- Datapath, fixed 2-cycle latency:
  - prev_q <= i_rxdata and prevk_q <= i_rxcharisk every cycle.
  - o_data <= low 8*BYTES bits of ({i_rxdata, prev_q} >> 8*o_offset); o_charisk is rotated the same way.
  - Output byte j = prev byte (offset+j) if offset+j < BYTES, else current byte (offset+j-BYTES).
  - The rotation uses the o_offset value held *before* this edge.
  - o_valid <= o_locked (pre-edge value).
- FSM, evaluated each i_rx_clk edge. i_rx_aligned=0 forces state HUNT and vcnt=mcnt=0 and overrides all transitions below.
  - HUNT: any_hit -> cand<=p, vcnt<=1.
    - If LOCK_CNT==1, go directly to LOCKED (offset<=p).
    - Otherwise go to VERIFY.
    - No hit: stay in HUNT.
  - VERIFY:
    - Hit with p==cand: vcnt<=vcnt+1. If vcnt+1==LOCK_CNT -> LOCKED, o_offset<=cand, mcnt<=0.
    - Hit with p!=cand: cand<=p, vcnt<=1, stay.
    - No hit: hold.
  - LOCKED: o_locked=1.
    - Hit with p==o_offset: mcnt<=0.
    - Hit with p!=o_offset: o_err_cnt +1 (saturates at 16'hFFFF); mcnt<=mcnt+1.
    - If mcnt+1==UNLOCK_CNT: -> HUNT, o_lock_lost=1 for one cycle, vcnt=mcnt=0.
    - No hit: hold (counters unchanged).
  - i_rx_aligned falling while LOCKED: -> HUNT, o_lock_lost pulses, o_err_cnt unchanged.
- Lock timing: o_locked rises at the edge sampling the LOCK_CNT-th consecutive same-lane comma word. o_offset changes on the same edge.
- o_offset holds its last locked value in HUNT/VERIFY. o_data keeps rotating by it; o_valid=0.
- o_err_cnt clears only on reset.
- Reset mid-lock: immediate return to reset values; no o_lock_lost pulse.
- BYTES=2 gives OFFW=1; no special cases.

Test Plan:
- Aligned stream, comma lane 0 (BYTES=4, words 32'hxxxxxxBC, charisk 4'b0001 every 4th word, i_rx_aligned=1) -> o_locked=1 after the 4th comma word; o_offset=0; o_data equals input delayed 2 cycles; o_valid follows o_locked one cycle later.
- Comma on lane 2 (32'h11BC2233 then 32'h44556677, charisk 4'b0100) -> after lock o_offset=2; the output word for that pair = 32'h667711BC with o_charisk=4'b0001.
- Interrupted verify: commas at lanes 1,1,3,3,3,3 -> lock only after the 4th lane-3 comma; o_offset=3; o_err_cnt=0.
- Lock loss: locked at lane 0, then 8 consecutive lane-1 commas -> o_err_cnt=8, o_lock_lost single pulse on the 8th, o_locked=0. A lane-0 comma after 7 misses -> mcnt clears and lock is kept.
- i_rx_aligned drops for 1 cycle while locked -> HUNT next edge, o_lock_lost=1, o_valid=0 two edges later; relock needs 4 fresh commas.
- Async reset asserted mid-VERIFY and while locked -> all outputs 0 immediately, without waiting for a clock edge; no pulse; o_err_cnt=0; relock is normal after release.
